// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU arbiter slice.
//   ALU_W       : operand / result width
//   alu_op_t    : ALU operation encoding (ADD, SUB, AND, NOT)
//   arb_state_t : arbiter sequencer states (IDLE, EXEC, RESP)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        AND = 2'd2,
        NOT = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// -----------------------------------------------------------------------------
// ALU
// Combinational 8-bit ALU shared by the arbiter's requesters.
// Ports:
//   op_i : operation (alu_op_t)
//   a_i  : operand a
//   b_i  : operand b (ignored for NOT)
//   y_o  : result; AND/NOT are logical and return 0 or 1
// -----------------------------------------------------------------------------
module ALU
    import alu_pkg::*;
(
    input  alu_op_t          op_i,
    input  logic [ALU_W-1:0] a_i,
    input  logic [ALU_W-1:0] b_i,
    output logic [ALU_W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            ADD:     y_o = a_i + b_i;
            SUB:     y_o = a_i - b_i;
            AND:     y_o = {{(ALU_W-1){1'b0}}, (|a_i) & (|b_i)};
            NOT:     y_o = {{(ALU_W-1){1'b0}}, ~(|a_i)};
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Two-way round-robin arbiter and sequencer in front of the shared ALU.
// One operation is in flight at a time: accept (IDLE) -> compute (EXEC) ->
// hold result until taken (RESP).
//
// State table:
//   IDLE | waiting for a request; grant and ready computed combinationally
//   EXEC | ALU driven from latched operands; result registered at end
//   RESP | rsp_valid high, result held until rsp_ready
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   reqN_valid/reqN_ready   : request handshake for requester N (0/1)
//   reqN_op, reqN_a, reqN_b : operation and operands of requester N
//   rsp_valid/rsp_ready     : response handshake
//   rsp_id, rsp_data        : owning requester and result
//   rsp_zero, rsp_carry     : result flags, present only with ALU_ARB_FLAGS_EN
//
// Build option: define ALU_ARB_FLAGS_EN to add the zero/carry flag outputs.
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int ID_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [ALU_W-1:0] req0_a,
    input  logic [ALU_W-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [ALU_W-1:0] req1_a,
    input  logic [ALU_W-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic [ALU_W-1:0] rsp_data
`ifdef ALU_ARB_FLAGS_EN
    ,
    output logic             rsp_zero,
    output logic             rsp_carry
`endif
);

    arb_state_t       state_q, state_d;
    alu_op_t          op_q;
    logic [ALU_W-1:0] a_q, b_q;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  last_grant_q;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [ALU_W-1:0] rsp_data_q;

    logic             accept;
    logic [ID_W-1:0]  grant_id;
    logic [ALU_W-1:0] alu_y;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        grant_id   = '0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant_id = (last_grant_q == ID_W'(0)) ? ID_W'(1) : ID_W'(0);
                end else if (req1_valid) begin
                    grant_id = ID_W'(1);
                end
                // Ready is masked by reset so nothing is accepted while held.
                accept     = rst_n && (req0_valid || req1_valid);
                req0_ready = accept && (grant_id == ID_W'(0));
                req1_ready = accept && (grant_id == ID_W'(1));
                if (req0_valid || req1_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    ALU u_alu (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= ADD;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            last_grant_q <= ID_W'(1);
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q         <= (grant_id == ID_W'(0)) ? alu_op_t'(req0_op) : alu_op_t'(req1_op);
                a_q          <= (grant_id == ID_W'(0)) ? req0_a : req1_a;
                b_q          <= (grant_id == ID_W'(0)) ? req0_b : req1_b;
                id_q         <= grant_id;
                last_grant_q <= grant_id;
            end
            if (state_q == EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_data_q  <= alu_y;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

`ifdef ALU_ARB_FLAGS_EN
    logic rsp_zero_q, rsp_carry_q;
    logic carry_c;

    always_comb begin
        carry_c = 1'b0;
        case (op_q)
            ADD:     carry_c = ({1'b0, a_q} + {1'b0, b_q}) > {1'b0, {ALU_W{1'b1}}};
            SUB:     carry_c = (a_q < b_q);
            default: carry_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_zero_q  <= (alu_y == '0);
            rsp_carry_q <= carry_c;
        end
    end

    assign rsp_zero  = rsp_zero_q;
    assign rsp_carry = rsp_carry_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed self-checking bench for alu_arbiter. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready;
    logic [0:0] rsp_id;
    logic [7:0] rsp_data;
`ifdef ALU_ARB_FLAGS_EN
    logic       rsp_zero, rsp_carry;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.ID_W(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
`ifdef ALU_ARB_FLAGS_EN
        ,
        .rsp_zero   (rsp_zero),
        .rsp_carry  (rsp_carry)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Waits (bounded) for requester id to see ready; returns at negedge+1.
    task automatic wait_ready(input string tag, input int id);
        bit got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (((id == 0) ? req0_ready : req1_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_accept"}, 32'(got), 32'd1);
        chk({tag, "_other_ready"}, 32'((id == 0) ? req1_ready : req0_ready), 32'd0);
    endtask

    // Full operation with rsp_ready high; starts and ends on a falling edge.
    task automatic do_op(input string tag, input int id, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_d, input logic exp_z, input logic exp_c);
        set_req(id, 1'b1, op, a, b);
        wait_ready(tag, id);
        @(negedge clk);
        set_req(id, 1'b0, op, a, b);
        #1;
        chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_d));
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
`ifdef ALU_ARB_FLAGS_EN
        chk({tag, "_zero"}, 32'(rsp_zero), 32'(exp_z));
        chk({tag, "_carry"}, 32'(rsp_carry), 32'(exp_c));
`else
        if (exp_z === 1'bx || exp_c === 1'bx) $display("note: unknown flag expectation in %s", tag);
`endif
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        set_req(0, 1'b0, ADD, 8'd0, 8'd0);
        set_req(1, 1'b0, ADD, 8'd0, 8'd0);

        // Reset values; ready must stay low during reset even with valid high.
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 200+100 -> 44 with carry; latency T -> T+2.
        do_op("add", 0, ADD, 8'd200, 8'd100, 8'd44, 1'b0, 1'b1);

        // Contention from a fresh reset: grants alternate 0,1,0,1.
        reset_pulse();
        set_req(0, 1'b1, SUB, 8'd5, 8'd7);
        set_req(1, 1'b1, SUB, 8'd5, 8'd7);
        for (int k = 0; k < 4; k++) begin
            bit got = 1'b0;
            for (int i = 0; i < 8; i++) begin
                #1;
                if ((req0_ready | req1_ready) === 1'b1) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("rr_accept", 32'(got), 32'd1);
            chk("rr_req0_ready", 32'(req0_ready), 32'((k % 2) == 0));
            chk("rr_req1_ready", 32'(req1_ready), 32'((k % 2) == 1));
            @(negedge clk);
            #1;
            chk("rr_exec_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
            @(negedge clk);
            #1;
            chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rr_rsp_data", 32'(rsp_data), 32'd254);
            chk("rr_rsp_id", 32'(rsp_id), 32'(k % 2));
`ifdef ALU_ARB_FLAGS_EN
            chk("rr_carry", 32'(rsp_carry), 32'd1);
`endif
            @(negedge clk);
        end
        set_req(0, 1'b0, SUB, 8'd0, 8'd0);
        set_req(1, 1'b0, SUB, 8'd0, 8'd0);

        // Logical ops from requester 1.
        do_op("and_a3_b0", 1, AND, 8'd3, 8'd0, 8'd0, 1'b1, 1'b0);
        do_op("and_a3_b9", 1, AND, 8'd3, 8'd9, 8'd1, 1'b0, 1'b0);
        do_op("not_a0", 1, NOT, 8'd0, 8'h55, 8'd1, 1'b0, 1'b0);

        // Back-pressure: result held for 5 cycles, no accepts meanwhile.
        rsp_ready = 1'b0;
        set_req(0, 1'b1, ADD, 8'd1, 8'd2);
        wait_ready("bp", 0);
        @(negedge clk);
        set_req(0, 1'b0, ADD, 8'd1, 8'd2);
        @(negedge clk);
        set_req(0, 1'b1, ADD, 8'd7, 8'd7);
        set_req(1, 1'b1, SUB, 8'd9, 8'd4);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'd3);
            chk("bp_rsp_id", 32'(rsp_id), 32'd0);
            chk("bp_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
            @(negedge clk);
            #1;
        end
        req0_valid = 1'b0;
        rsp_ready  = 1'b1;
        #1;
        chk("hs_cycle_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
        chk("hs_cycle_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        #1;
        chk("after_hs_req1_ready", 32'(req1_ready), 32'd1);
        chk("after_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        set_req(1, 1'b0, SUB, 8'd9, 8'd4);
        @(negedge clk);
        #1;
        chk("after_hs_rsp_data", 32'(rsp_data), 32'd5);
        chk("after_hs_rsp_id", 32'(rsp_id), 32'd1);
`ifdef ALU_ARB_FLAGS_EN
        chk("after_hs_carry", 32'(rsp_carry), 32'd0);
`endif
        @(negedge clk);

        // Reset during EXEC drops the operation; req0 wins afterwards.
        set_req(0, 1'b1, ADD, 8'd10, 8'd20);
        wait_ready("rst_exec", 0);
        @(negedge clk);
        set_req(0, 1'b0, ADD, 8'd10, 8'd20);
        rst_n = 1'b0;
        #1;
        chk("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_exec_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        set_req(0, 1'b1, SUB, 8'd1, 8'd1);
        set_req(1, 1'b1, SUB, 8'd1, 8'd1);
        #1;
        chk("post_rst_req0_wins", 32'(req0_ready), 32'd1);
        chk("post_rst_req1_waits", 32'(req1_ready), 32'd0);
        @(negedge clk);
        set_req(0, 1'b0, SUB, 8'd0, 8'd0);
        set_req(1, 1'b0, SUB, 8'd0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and two-way round-robin arbiter that shares the single 8-bit ALU between two requesters, such as the instruction datapath and the address/PC update path. It accepts one operation at a time through a valid/ready handshake and drives the ALU from registered operands. It returns the registered result, tagged with the winning requester, through a response handshake. It sits between the control unit's requesters and the ALU instance; the ALU itself stays combinational.

## Interface
- `ID_W`, default 1: requester-id width; fixed for two requesters.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: requester N has an operation pending.
- `req0_ready` / `req1_ready` out 1: operation of requester N accepted this cycle.
- `req0_op` / `req1_op` in 2: ALU op (ADD=0, SUB=1, AND=2, NOT=3).
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in 8: operands.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_id` out 1: requester that owns the result.
- `rsp_data` out 8: result.
- `rsp_zero`, `rsp_carry` out 1: only with `ALU_ARB_FLAGS_EN`.

## Operation
- The FSM has three states.
  - IDLE → EXEC when any `reqN_valid` is high.
  - EXEC → RESP unconditionally.
  - RESP → IDLE on `rsp_valid && rsp_ready`.
- Grant is computed combinationally in IDLE.
  - With one valid requester, that requester is granted.
  - With both valid, the requester not equal to `last_grant` is granted.
- `reqN_ready` = (state==IDLE) && granted==N.
- On acceptance the block latches op, a, b and the id, and updates `last_grant` to the id.
- Requester inputs are ignored outside IDLE; ready stays low there. Requesters must hold valid and payload until ready.
- In EXEC the ALU is driven from the latched operands, and its output is registered into `rsp_data` at the end of EXEC.
- ALU semantics are those of the existing ALU module:
  - ADD: a+b mod 256.
  - SUB: a−b mod 256.
  - AND: logical; 8'd1 if a≠0 and b≠0, else 8'd0.
  - NOT: logical; 8'd1 if a==0, else 8'd0. b is ignored.
- In RESP, `rsp_valid`=1 and `rsp_data`/`rsp_id` are held stable until the handshake completes.
- Back-pressure: a low `rsp_ready` holds RESP indefinitely, and no new request is accepted meanwhile.

## Timing
- Reset values: state=IDLE, `last_grant`=1 (so req0 wins the first contention), `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, flags=0. `req*_ready` are 0 during reset.
- Latency: request accepted in cycle T (ready high) → `rsp_valid` rises in cycle T+2.
- Best-case throughput is one operation per 3 cycles. With `rsp_ready` tied high, the next accept happens in cycle T+3.
- Simultaneous requests: exactly one ready per cycle, never both.
- The response handshake and a new request in the same cycle: the request waits. It is accepted in the following IDLE cycle.
- Reset asserted mid-operation: all state is cleared immediately. The in-flight operation is dropped and no response is issued.

## Configuration
- `ALU_ARB_FLAGS_EN` defined:
  - Adds the `rsp_zero` and `rsp_carry` ports, registered with `rsp_data`.
  - `rsp_zero` = (result==0).
  - `rsp_carry`:
    - ADD: carry-out of the 9-bit sum.
    - SUB: borrow (a<b).
    - AND/NOT: 0.
- `ALU_ARB_FLAGS_EN` undefined: the ports and flag registers are absent. Behaviour is otherwise identical.

## Structure
- Shared package `alu_pkg` holds:
  - the op constants ADD/SUB/AND/NOT as a 2-bit typedef `alu_op_t`;
  - the FSM state typedef `arb_state_t` (IDLE, EXEC, RESP);
  - the operand width constant `ALU_W`=8.
- Sub-module: one instance of the existing combinational `ALU` module, fed from the operand registers. Flag logic lives in `alu_arbiter`, not in `ALU`.

## Test plan
- Reset, then req0 ADD a=8'd200 b=8'd100, `rsp_ready`=1 → `req0_ready` high in T, `rsp_valid` in T+2 with `rsp_data`=8'd44, `rsp_id`=0; with flags, carry=1 and zero=0.
- req0 and req1 valid every cycle, both SUB a=5 b=7 → grants alternate 0,1,0,1 starting with 0; each `rsp_data`=8'd254; with flags, carry=1.
- req1 AND a=3 b=0, then AND a=3 b=9, then NOT a=0 → `rsp_data` 0, then 1, then 1; zero flag 1, then 0, then 0.
- Response accepted, `rsp_ready` low for 5 cycles → `rsp_valid`/`rsp_data` stable throughout, both `req*_ready` low; the next accept occurs the cycle after the handshake.
- `rst_n` pulled low in EXEC → `rsp_valid` stays 0 and state returns to IDLE; after release, req0 wins the first contention.
